// File: rtl/decode_stage.sv
// Instruction-decode stage: splits the instruction into fields, reads two operands
// from a 32-entry register file with write-through bypass, and registers everything.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction,
  output logic [6:0]      opcode,
  output logic [4:0]      dst,
  output logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] src2,
  output logic [9:0]      offsetlo,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] rf_reg [NREGS];

  logic [6:0]      opcode_reg,   opcode_next;
  logic [4:0]      dst_reg,      dst_next;
  logic [XLEN-1:0] src1_reg,     src1_next;
  logic [XLEN-1:0] src2_reg,     src2_next;
  logic [9:0]      offsetlo_reg, offsetlo_next;

  logic [AW-1:0]   src1_idx, src2_idx;
  logic [XLEN-1:0] src1_rd, src2_rd;
  logic            wb_live;

  assign src1_idx = instruction[19:15];
  assign src2_idx = instruction[14:10];
  // A write to r0 is a no-op, so it must neither land nor bypass.
  assign wb_live  = wb_en && (wb_addr != '0);

  // The write path depends only on the writeback port, so an X-laden
  // instruction can never reach the register contents.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_rf
      always_ff @(posedge clk) begin
        if (reset) begin
          rf_reg[gi] <= '0;
        end else if (gi != 0 && wb_live && wb_addr == AW'(gi)) begin
          rf_reg[gi] <= wb_data;
        end
      end
    end
  endgenerate

  always_comb begin
    src1_rd = rf_reg[src1_idx];
    if (src1_idx == '0) begin
      src1_rd = '0;
    end else if (wb_live && wb_addr == src1_idx) begin
      src1_rd = wb_data;
    end
  end

  always_comb begin
    src2_rd = rf_reg[src2_idx];
    if (src2_idx == '0) begin
      src2_rd = '0;
    end else if (wb_live && wb_addr == src2_idx) begin
      src2_rd = wb_data;
    end
  end

  // Flush beats stall: a bubble is inserted even while the stage is held.
  always_comb begin
    opcode_next   = opcode_reg;
    dst_next      = dst_reg;
    src1_next     = src1_reg;
    src2_next     = src2_reg;
    offsetlo_next = offsetlo_reg;
    if (flush) begin
      opcode_next   = '0;
      dst_next      = '0;
      src1_next     = '0;
      src2_next     = '0;
      offsetlo_next = '0;
    end else if (!stall) begin
      opcode_next   = instruction[31:25];
      dst_next      = instruction[24:20];
      src1_next     = src1_rd;
      src2_next     = src2_rd;
      offsetlo_next = instruction[9:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_reg   <= '0;
      dst_reg      <= '0;
      src1_reg     <= '0;
      src2_reg     <= '0;
      offsetlo_reg <= '0;
    end else begin
      opcode_reg   <= opcode_next;
      dst_reg      <= dst_next;
      src1_reg     <= src1_next;
      src2_reg     <= src2_next;
      offsetlo_reg <= offsetlo_next;
    end
  end

  assign opcode   = opcode_reg;
  assign dst      = dst_reg;
  assign src1     = src1_reg;
  assign src2     = src2_reg;
  assign offsetlo = offsetlo_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed vectors checked with immediate assertions.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [4:0]  dst;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [9:0]  offsetlo;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int errors = 0;
  int checks = 0;

  decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .opcode      (opcode),
    .dst         (dst),
    .src1        (src1),
    .src2        (src2),
    .offsetlo    (offsetlo),
    .stall       (stall),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [6:0] e_op, input logic [4:0] e_dst,
                           input logic [31:0] e_s1, input logic [31:0] e_s2, input logic [9:0] e_off);
    check({tag, ".opcode"},   {25'd0, opcode},   {25'd0, e_op});
    check({tag, ".dst"},      {27'd0, dst},      {27'd0, e_dst});
    check({tag, ".src1"},     src1,              e_s1);
    check({tag, ".src2"},     src2,              e_s2);
    check({tag, ".offsetlo"}, {22'd0, offsetlo}, {22'd0, e_off});
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2, input logic [9:0] off);
    return {op, d, s1, s2, off};
  endfunction

  initial begin
    reset = 1'b1; instruction = '0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    // Reset held for two edges
    tick(); tick();
    check_all("reset", 7'h00, 5'd0, 32'h0, 32'h0, 10'h0);

    reset = 1'b0;
    instruction = mk(7'h00, 5'd0, 5'd1, 5'd12, 10'd0);
    tick();
    check("post_reset.src1", src1, 32'h0);
    check("post_reset.src2", src2, 32'h0);

    // Fill RF[1] and RF[12], then basic decode
    wb_en = 1'b1; wb_addr = 5'd1;  wb_data = 32'h1111_1111; tick();
    wb_addr = 5'd12; wb_data = 32'hCCCC_0000; tick();
    wb_en = 1'b0;
    instruction = mk(7'h01, 5'd3, 5'd1, 5'd12, 10'd0);
    tick();
    check_all("basic", 7'h01, 5'd3, 32'h1111_1111, 32'hCCCC_0000, 10'h0);

    // Write to r0 is ignored and does not bypass
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    instruction = mk(7'h02, 5'd4, 5'd0, 5'd1, 10'h155);
    tick();
    check("r0_wr.src1", src1, 32'h0);
    check("r0_wr.src2", src2, 32'h1111_1111);
    check("r0_wr.offsetlo", {22'd0, offsetlo}, 32'h155);
    wb_en = 1'b0;
    tick();
    check("r0_after.src1", src1, 32'h0);

    // Bypass to both operands from the same index
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    instruction = mk(7'h03, 5'd6, 5'd5, 5'd5, 10'd0);
    tick();
    check("bypass_both.src1", src1, 32'hDEAD_BEEF);
    check("bypass_both.src2", src2, 32'hDEAD_BEEF);
    wb_en = 1'b0;
    tick();
    check("written_r5.src1", src1, 32'hDEAD_BEEF);
    check("written_r5.src2", src2, 32'hDEAD_BEEF);

    // Bypass to src2 only
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'h1234_5678;
    instruction = mk(7'h04, 5'd2, 5'd1, 5'd12, 10'd0);
    tick();
    check("bypass_s2.src1", src1, 32'h1111_1111);
    check("bypass_s2.src2", src2, 32'h1234_5678);

    // All-ones instruction reads r31 on both ports
    wb_addr = 5'd31; wb_data = 32'hA5A5_A5A5; tick();
    wb_en = 1'b0;
    instruction = 32'hFFFF_FFFF;
    tick();
    check_all("ones", 7'h7F, 5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 10'h3FF);

    // Stall for three edges while the instruction changes; RF write proceeds
    stall = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h2222_2222;
    instruction = mk(7'h11, 5'd1, 5'd1, 5'd1, 10'h001);
    tick();
    check_all("stall1", 7'h7F, 5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 10'h3FF);
    wb_en = 1'b0;
    instruction = mk(7'h22, 5'd2, 5'd12, 5'd5, 10'h002);
    tick();
    check_all("stall2", 7'h7F, 5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 10'h3FF);
    instruction = 32'h0000_0000;
    tick();
    check_all("stall3", 7'h7F, 5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 10'h3FF);
    stall = 1'b0;
    instruction = mk(7'h01, 5'd3, 5'd1, 5'd12, 10'd7);
    tick();
    check_all("after_stall", 7'h01, 5'd3, 32'h2222_2222, 32'h1234_5678, 10'd7);

    // Flush inserts a bubble
    flush = 1'b1;
    instruction = 32'hFFFF_FFFF;
    tick();
    check_all("flush", 7'h00, 5'd0, 32'h0, 32'h0, 10'h0);
    flush = 1'b0;
    instruction = mk(7'h06, 5'd9, 5'd5, 5'd31, 10'h2AA);
    tick();
    check_all("refill", 7'h06, 5'd9, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 10'h2AA);
    flush = 1'b1; stall = 1'b1;
    tick();
    check_all("flush_stall", 7'h00, 5'd0, 32'h0, 32'h0, 10'h0);

    // Reset discards a concurrent write to r7 and clears the RF
    flush = 1'b0; stall = 1'b0;
    reset = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h7777_7777;
    instruction = mk(7'h05, 5'd1, 5'd7, 5'd1, 10'h0);
    tick();
    check_all("mid_reset", 7'h00, 5'd0, 32'h0, 32'h0, 10'h0);
    reset = 1'b0; wb_en = 1'b0;
    tick();
    check_all("after_reset", 7'h05, 5'd1, 32'h0, 32'h0, 10'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
